led_arb: RTL
============

Name: led_arb

Overview:
Arbiter and sequencer for the board's 8 user LEDs, shared by three sources:
- Software LED register, written over the I/O bus.
- System error-code display, which blinks an 8-bit code for a bounded time.
- Heartbeat indicator on LED 7.

Sits between the processor I/O bus and the LED pins, replacing direct software ownership of the LEDs.

Parameters:
BLINK_CYC, 25_000_000, length in clk cycles of one blink phase (on or off); must be >= 2
N_BLINKS, 4, number of on/off blink pairs per error display; must be >= 1
HB_CYC, 50_000_000, heartbeat half-period in clk cycles; must be >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stb  in  1  bus strobe, one cycle per access
we  in  1  1 = write, 0 = read
addr  in  1  register select: 0 = LED, 1 = CTRL/STATUS
data_in  in  32  write data
data_out  out  32  read data; 0 when not (stb & ~we)
ack  out  1  equals stb (zero wait states)
err_valid  in  1  one-cycle pulse: new error code present
err_code  in  8  error code, sampled when err_valid = 1
leds  out  8  LED pins
err_active  out  1  1 while the error display is running

Behaviour:
Clock and reset
- One clock (clk); synchronous, active-high reset (rst).
- Reset: sw_led = 0, hb_en = 0, err_en = 1, state = IDLE, all counters = 0, hb = 0, latched code = 0.
- Hence after reset: leds = 0, err_active = 0.
- Reset mid-display aborts immediately; leds = 0 on the cycle after rst.

Register writes (stb & we)
- addr 0: sw_led <= data_in[7:0].
- addr 1: hb_en <= data_in[0]; err_en <= data_in[1]; data_in[2] = err_clr (self-clearing strobe, not stored).

Register reads (stb & ~we), combinational
- addr 0: {24'b0, sw_led}.
- addr 1: {8'b0, code[7:0], 7'b0, err_active, 5'b0, 1'b0, err_en, hb_en}.

Error FSM states: IDLE, SHOW_ON, SHOW_OFF.
- IDLE -> SHOW_ON: on err_valid & err_en. Latch code <= err_code, timer <= BLINK_CYC-1, blinks <= 0.
- SHOW_ON: when timer == 0 -> SHOW_OFF, timer reloaded.
- SHOW_OFF: when timer == 0:
  - blinks == N_BLINKS-1 -> IDLE;
  - else -> SHOW_ON with blinks+1 and timer reloaded.
- Otherwise, in SHOW_ON/SHOW_OFF the timer decrements each cycle.
- Each phase therefore lasts exactly BLINK_CYC cycles; a full display lasts 2*N_BLINKS*BLINK_CYC cycles.
- err_valid while in SHOW_ON or SHOW_OFF (and err_en = 1): re-latch code, restart at SHOW_ON with full timer and blinks = 0 (latest error wins).
- err_clr while not IDLE: next state IDLE.
- err_valid and err_clr in the same cycle: err_valid wins and the display restarts.
- err_en = 0: err_valid is ignored; a running display is not aborted.
- err_active = (state != IDLE).

Heartbeat
- When hb_en = 1, a counter counts 0..HB_CYC-1 and wraps; hb toggles on wrap.
- When hb_en = 0, the counter is held at 0 and hb = 0.

LED output mux (priority: error display > heartbeat > software)
- SHOW_ON: leds = code.
- SHOW_OFF: leds = 0.
- IDLE: leds = {hb_en ? hb : sw_led[7], sw_led[6:0]}.
- leds is driven only from registered state, with no combinational input-to-output path, so an event at edge N is visible after edge N.

Width rules
- Timer width = clog2(BLINK_CYC); blink counter width = clog2(N_BLINKS+1); heartbeat counter width = clog2(HB_CYC).

Decomposition:
- Package led_arb_pkg holds:
  - state encoding (IDLE = 2'd0, SHOW_ON = 2'd1, SHOW_OFF = 2'd2);
  - register addresses (ADDR_LED = 0, ADDR_CTRL = 1);
  - CTRL bit positions (HB_EN = 0, ERR_EN = 1, ERR_CLR = 2, ERR_ACTIVE = 8, CODE_LSB = 16).
- One sub-module, led_hb: the heartbeat divider (inputs clk, rst, en; output hb; parameter HB_CYC).

Test Plan:
Bench parameters: BLINK_CYC = 4, N_BLINKS = 2, HB_CYC = 8.
1. Reset and software: after rst, leds = 0 and a read of addr 1 returns 0x0000_0002. Write addr 0 = 0xA5 -> leds = 0xA5 next cycle; read addr 0 = 0x0000_00A5; ack = stb on every access.
2. Heartbeat: with sw_led = 0xFF, write addr 1 = 0x3 -> leds[7] = 0 for 8 cycles, then 1 for 8, repeating; leds[6:0] = 0x7F. Write addr 1 = 0x2 -> leds[7] = 1 again (from sw_led) and the counter resets.
3. Error display: err_valid with err_code = 0x3C -> leds = 0x3C for 4 cycles, 0 for 4, 0x3C for 4, 0 for 4, then back to sw_led. err_active is 1 for exactly 16 cycles; addr 1 read shows bits[23:16] = 0x3C and bit8 = 1 during the display.
4. Restart and clear: err_valid 0x11, then err_valid 0x22 at cycle 6 -> 0x22 shown with a full 16-cycle sequence. A write of addr 1 = 0x6 mid-display -> IDLE next cycle. Same-cycle err_valid and err_clr -> display restarts.
5. Masking: err_en = 0 and err_valid -> no state change, err_active stays 0. Disabling err_en mid-display -> the display completes.
6. Reset mid-display: assert rst during SHOW_ON -> next cycle leds = 0, err_active = 0, hb_en = 0, err_en = 1.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared encodings for the LED arbiter: error-display states, register map
// and CTRL/STATUS bit positions.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_ON  = 2'd1,
        SHOW_OFF = 2'd2
    } err_state_t;

    localparam logic ADDR_LED  = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int HB_EN      = 0;
    localparam int ERR_EN     = 1;
    localparam int ERR_CLR    = 2;
    localparam int ERR_ACTIVE = 8;
    localparam int CODE_LSB   = 16;

endpackage

// File: rtl/led_hb.sv
// Heartbeat divider: hb toggles every HB_CYC cycles while en is high,
// and is held low with the counter cleared while en is low.
module led_hb #(
    parameter int HB_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic hb
);

    localparam int CW = $clog2(HB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(HB_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            hb  <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            hb  <= ~hb;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_arb.sv
// LED arbiter: error-code blink display over heartbeat over software LEDs,
// with a two-register bus interface (LED, CTRL/STATUS).
module led_arb
    import led_arb_pkg::*;
#(
    parameter int BLINK_CYC = 25_000_000,
    parameter int N_BLINKS  = 4,
    parameter int HB_CYC    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        err_valid,
    input  logic [7:0]  err_code,
    output logic [7:0]  leds,
    output logic        err_active
);

    localparam int TW = $clog2(BLINK_CYC);
    localparam int BW = $clog2(N_BLINKS + 1);
    localparam logic [TW-1:0] TIMER_TOP  = TW'(BLINK_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(N_BLINKS - 1);

    err_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [BW-1:0] blinks, blinks_nx;
    logic [7:0]    code, code_nx;
    logic [7:0]    sw_led;
    logic          hb_en, err_en, hb;
    logic          wr_led, wr_ctrl, err_clr;
    logic [31:0]   ctrl_word;
    logic          unused_bits;

    assign wr_led      = stb && we && (addr == ADDR_LED);
    assign wr_ctrl     = stb && we && (addr == ADDR_CTRL);
    assign err_clr     = wr_ctrl && data_in[ERR_CLR];
    assign unused_bits = ^data_in[31:8];
    assign ack         = stb;
    assign err_active  = (state != IDLE);

    led_hb #(.HB_CYC(HB_CYC)) u_hb (
        .clk (clk),
        .rst (rst),
        .en  (hb_en),
        .hb  (hb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            blinks <= '0;
            code   <= '0;
            sw_led <= '0;
            hb_en  <= 1'b0;
            err_en <= 1'b1;
        end else begin
            state  <= state_nx;
            timer  <= timer_nx;
            blinks <= blinks_nx;
            code   <= code_nx;
            if (wr_led)
                sw_led <= data_in[7:0];
            if (wr_ctrl) begin
                hb_en  <= data_in[HB_EN];
                err_en <= data_in[ERR_EN];
            end
        end
    end

    // A new error always restarts the display, even when a clear arrives with it.
    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        blinks_nx = blinks;
        code_nx   = code;
        if (err_valid && err_en) begin
            state_nx  = SHOW_ON;
            timer_nx  = TIMER_TOP;
            blinks_nx = '0;
            code_nx   = err_code;
        end else if (err_clr && state != IDLE) begin
            state_nx = IDLE;
        end else begin
            case (state)
                SHOW_ON: begin
                    if (timer == '0) begin
                        state_nx = SHOW_OFF;
                        timer_nx = TIMER_TOP;
                    end else begin
                        timer_nx = timer - 1'b1;
                    end
                end
                SHOW_OFF: begin
                    if (timer == '0) begin
                        if (blinks == BLINK_LAST) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx  = SHOW_ON;
                            timer_nx  = TIMER_TOP;
                            blinks_nx = blinks + 1'b1;
                        end
                    end else begin
                        timer_nx = timer - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state)
            SHOW_ON:  leds = code;
            SHOW_OFF: leds = 8'h00;
            default:  leds = {hb_en ? hb : sw_led[7], sw_led[6:0]};
        endcase
    end

    always_comb begin
        ctrl_word                  = '0;
        ctrl_word[HB_EN]           = hb_en;
        ctrl_word[ERR_EN]          = err_en;
        ctrl_word[ERR_ACTIVE]      = err_active;
        ctrl_word[CODE_LSB +: 8]   = code;
        data_out = '0;
        if (stb && !we)
            data_out = (addr == ADDR_CTRL) ? ctrl_word : {24'b0, sw_led};
    end

endmodule
